water_inlet_arbiter: RTL and testbench

WATER_INLET_ARBITER -- requirements
Module: water_inlet_arbiter

---
 rtl/water_inlet_pkg.sv | 46 ++++
 rtl/rr_pick4.sv | 28 ++
 rtl/water_inlet_arbiter.sv | 157 +++++++++++++++
 tb/tb_water_inlet_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/water_inlet_pkg.sv
// Shared types for the water inlet arbiter: FSM encoding, temperature codes,
// valve drive struct and default parameter values.
package water_inlet_pkg;

    localparam int DEF_N_REQ           = 4;
    localparam int DEF_GUARD_CYCLES    = 2;
    localparam int DEF_MAX_FILL_CYCLES = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        COLD = 2'b00,
        HOT  = 2'b01,
        WARM = 2'b10,
        RSVD = 2'b11
    } temp_t;

    typedef struct packed {
        logic cold;
        logic hot;
    } valve_t;

    // Reserved code falls back to cold so a bad selector never scalds.
    function automatic valve_t temp_to_valves(input logic [1:0] code);
        valve_t v;
        v.cold = 1'b1;
        v.hot  = 1'b0;
        case (temp_t'(code))
            HOT: begin
                v.cold = 1'b0;
                v.hot  = 1'b1;
            end
            WARM: begin
                v.cold = 1'b1;
                v.hot  = 1'b1;
            end
            default: ;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: lowest set bit searching upward
// from ptr+1, wrapping modulo 4.
module rr_pick4
    import water_inlet_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       found,
    output logic [1:0] idx
);

    logic [1:0] start;
    logic [7:0] dbl;
    logic [3:0] rot;

    assign start = ptr + 2'd1;
    assign dbl   = {req, req};
    assign rot   = dbl[start +: 4];

    always_comb begin
        found = |rot;
        idx   = start;
        for (int k = 3; k >= 0; k--) begin
            if (rot[k]) idx = start + 2'(k);
        end
    end

endmodule

// File: rtl/water_inlet_arbiter.sv
// Shared water inlet arbiter: round-robin grant, latched temperature, guard gap.
// Optional fill timeout enabled by defining WATER_INLET_FILL_TIMEOUT_EN.
module water_inlet_arbiter
    import water_inlet_pkg::*;
#(
    parameter int N_REQ           = DEF_N_REQ,
    parameter int GUARD_CYCLES    = DEF_GUARD_CYCLES,
    parameter int MAX_FILL_CYCLES = DEF_MAX_FILL_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [2*N_REQ-1:0]   temp_sel,
    input  logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     grant,
    output logic [1:0]           grant_id,
    output logic                 valve_in_cold,
    output logic                 valve_in_hot,
    output logic                 busy,
    output logic [N_REQ-1:0]     timeout
);

    localparam logic [3:0] GUARD_LIM = 4'(GUARD_CYCLES);

    // Out-of-range configurations elaborate a marker scope only; the picker is 4-wide.
    if (N_REQ != 4 || GUARD_CYCLES < 1 || GUARD_CYCLES > 15 ||
        MAX_FILL_CYCLES < 1 || MAX_FILL_CYCLES > 255) begin : g_unsupported_cfg
    end

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [1:0]       gid_q, gid_d;
    logic [1:0]       rr_q, rr_d;
    valve_t           valves_q, valves_d;
    logic             busy_q, busy_d;
    logic [3:0]       guard_q, guard_d;

    logic             pick_found;
    logic [1:0]       pick_idx;
    logic             release_now;
    logic             fill_hit;

    rr_pick4 u_pick (
        .req   (req[3:0]),
        .ptr   (rr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign release_now = done[gid_q] | ~req[gid_q];

`ifdef WATER_INLET_FILL_TIMEOUT_EN
    localparam logic [7:0] FILL_LIM = 8'(MAX_FILL_CYCLES);

    logic [7:0]       fill_q, fill_d;
    logic [N_REQ-1:0] to_q, to_d;

    assign fill_hit = (fill_q == FILL_LIM);
    assign timeout  = to_q;
`else
    assign fill_hit = 1'b0;
    assign timeout  = '0;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gid_d    = gid_q;
        rr_d     = rr_q;
        valves_d = valves_q;
        busy_d   = busy_q;
        guard_d  = guard_q;
`ifdef WATER_INLET_FILL_TIMEOUT_EN
        fill_d   = fill_q;
        to_d     = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d           = ST_GRANT;
                    gid_d             = pick_idx;
                    rr_d              = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    valves_d          = temp_to_valves(temp_sel[{pick_idx, 1'b0} +: 2]);
                    busy_d            = 1'b1;
`ifdef WATER_INLET_FILL_TIMEOUT_EN
                    fill_d            = 8'd1;
`endif
                end
            end
            ST_GRANT: begin
                // A genuine release wins over the limit, so no timeout pulse then.
                if (release_now || fill_hit) begin
                    state_d  = ST_GUARD;
                    grant_d  = '0;
                    valves_d = '0;
                    busy_d   = 1'b0;
                    guard_d  = 4'd1;
`ifdef WATER_INLET_FILL_TIMEOUT_EN
                    fill_d   = '0;
                    if (!release_now) to_d[gid_q] = 1'b1;
`endif
                end
`ifdef WATER_INLET_FILL_TIMEOUT_EN
                else if (fill_q != 8'hFF) begin
                    fill_d = fill_q + 8'd1;
                end
`endif
            end
            ST_GUARD: begin
                if (guard_q >= GUARD_LIM) begin
                    state_d = ST_IDLE;
                    guard_d = '0;
                end else begin
                    guard_d = guard_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            gid_q    <= '0;
            rr_q     <= 2'd3;
            valves_q <= '0;
            busy_q   <= 1'b0;
            guard_q  <= '0;
`ifdef WATER_INLET_FILL_TIMEOUT_EN
            fill_q   <= '0;
            to_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gid_q    <= gid_d;
            rr_q     <= rr_d;
            valves_q <= valves_d;
            busy_q   <= busy_d;
            guard_q  <= guard_d;
`ifdef WATER_INLET_FILL_TIMEOUT_EN
            fill_q   <= fill_d;
            to_q     <= to_d;
`endif
        end
    end

    assign grant         = grant_q;
    assign grant_id      = gid_q;
    assign valve_in_cold = valves_q.cold;
    assign valve_in_hot  = valves_q.hot;
    assign busy          = busy_q;

endmodule

// File: tb/tb_water_inlet_arbiter.sv
// Bench for water_inlet_arbiter: directed scenarios plus random traffic, every
// cycle compared against a rule-level model of the inlet sharing protocol.
module tb_water_inlet_arbiter;

    localparam int G    = 2;
    localparam int MAXF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [7:0] temp_sel = '0;
    logic [3:0] done = '0;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       valve_in_cold, valve_in_hot, busy;
    logic [3:0] timeout;

    int checks = 0;
    int errors = 0;

    // Model: who owns the inlet (-1 = nobody), last winner, zero-grant cycles
    // still to sit out, cycles the current owner has held it, latched valves.
    int         m_owner = -1;
    int         m_ptr   = 3;
    int         m_gap   = 0;
    int         m_fill  = 0;
    logic       m_cold  = 1'b0;
    logic       m_hot   = 1'b0;
    logic [3:0] m_to    = '0;

    always #5 clk = ~clk;

    water_inlet_arbiter #(
        .N_REQ           (4),
        .GUARD_CYCLES    (G),
        .MAX_FILL_CYCLES (MAXF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .temp_sel      (temp_sel),
        .done          (done),
        .grant         (grant),
        .grant_id      (grant_id),
        .valve_in_cold (valve_in_cold),
        .valve_in_hot  (valve_in_hot),
        .busy          (busy),
        .timeout       (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit rel, hit, found;
        int c;
        if (rst) begin
            m_owner = -1; m_ptr = 3; m_gap = 0; m_fill = 0;
            m_cold = 1'b0; m_hot = 1'b0; m_to = '0;
        end else begin
            m_to = '0;
            if (m_owner >= 0) begin
                rel = done[m_owner] || !req[m_owner];
                hit = 1'b0;
`ifdef WATER_INLET_FILL_TIMEOUT_EN
                hit = (m_fill == MAXF);
`endif
                if (rel || hit) begin
                    if (!rel) m_to[m_owner] = 1'b1;
                    m_owner = -1; m_gap = G; m_fill = 0;
                    m_cold = 1'b0; m_hot = 1'b0;
                end else begin
                    m_fill++;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else begin
                found = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    c = (m_ptr + k) % 4;
                    if (!found && req[c]) begin
                        found = 1'b1;
                        m_owner = c; m_ptr = c; m_fill = 1;
                        case (temp_sel[2*c +: 2])
                            2'b01:   begin m_cold = 1'b0; m_hot = 1'b1; end
                            2'b10:   begin m_cold = 1'b1; m_hot = 1'b1; end
                            default: begin m_cold = 1'b1; m_hot = 1'b0; end
                        endcase
                    end
                end
            end
        end
    endtask

    // One clock: model steps on the same sampled inputs, outputs checked 1 after.
    task automatic cyc();
        logic [31:0] eg;
        @(posedge clk);
        model_edge();
        #1;
        eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        chk("m_grant", 32'(grant), eg);
        chk("m_busy", 32'(busy), 32'(m_owner >= 0));
        chk("m_valves", 32'({valve_in_cold, valve_in_hot}), 32'({m_cold, m_hot}));
        chk("m_timeout", 32'(timeout), 32'(m_to));
        if (m_owner >= 0) chk("m_grant_id", 32'(grant_id), 32'(m_owner));
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; done = '0;
        cyc();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valves", 32'({valve_in_cold, valve_in_hot}), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        rst = 1'b0;
    endtask

    initial begin
        int gap, cnt;
        int order [5] = '{0, 1, 2, 3, 0};

        // Basic hot grant, release and guard gap
        do_reset();
        req = 4'b0001; temp_sel = 8'h01;
        cyc();
        chk("s1_grant", 32'(grant), 32'b0001);
        chk("s1_hot", 32'(valve_in_hot), 1);
        chk("s1_cold", 32'(valve_in_cold), 0);
        chk("s1_busy", 32'(busy), 1);
        repeat (4) cyc();
        done = 4'b0001;
        cyc();
        done = '0;
        chk("s1_release", 32'(grant), 0);
        cyc(); chk("s1_guard", 32'(grant), 0);
        cyc(); chk("s1_idle", 32'(grant), 0);
        cyc(); chk("s1_regrant", 32'(grant), 32'b0001);

        // Round-robin rotation with all four requesting
        do_reset();
        req = 4'b1111; temp_sel = 8'($urandom);
        for (int n = 0; n < 5; n++) begin
            gap = 0;
            while (grant == 4'b0000 && gap < 20) begin
                gap++;
                cyc();
            end
            chk("rr_order", 32'(grant), 32'd1 << order[n]);
            if (n > 0) chk("rr_gap", gap, G + 1);
            repeat (3) cyc();
            done = grant;
            cyc();
            done = '0;
        end

        // Temperature latched at grant
        do_reset();
        req = 4'b0100; temp_sel = 8'b0010_0000;
        cyc();
        chk("warm_grant", 32'(grant), 32'b0100);
        temp_sel = 8'h00;
        repeat (3) begin
            cyc();
            chk("warm_hold", 32'({valve_in_cold, valve_in_hot}), 32'b11);
        end
        done = 4'b0100;
        cyc();
        done = '0; req = '0;
        chk("warm_closed", 32'({valve_in_cold, valve_in_hot}), 0);

        // Fill limit
        do_reset();
        req = 4'b0100; temp_sel = 8'($urandom);
`ifdef WATER_INLET_FILL_TIMEOUT_EN
        cnt = 0;
        cyc();
        while (grant == 4'b0100 && cnt < 100) begin
            cnt++;
            cyc();
        end
        chk("fill_len", cnt, MAXF);
        chk("to_pulse", 32'(timeout), 32'b0100);
        cyc(); chk("to_clear", 32'(timeout), 0);
        cyc(); chk("to_gap", 32'(grant), 0);
        cyc(); chk("to_regrant", 32'(grant), 32'b0100);
`else
        cnt = 0;
        repeat (40) begin
            cyc();
            if (grant == 4'b0100) cnt++;
        end
        chk("unlimited_len", cnt, 40);
        chk("no_timeout", 32'(timeout), 0);
`endif
        req = '0;
        cyc();

        // Reset mid-grant
        do_reset();
        req = 4'b0010; temp_sel = 8'hFF;
        cyc(); cyc();
        rst = 1'b1; req = 4'b1000;
        cyc();
        chk("rst_mid_outs", 32'({grant, busy, valve_in_cold, valve_in_hot, timeout, grant_id}), 0);
        rst = 1'b0;
        cyc();
        chk("rst_mid_w3", 32'(grant), 32'b1000);

        // Release and new request on the same edge
        do_reset();
        req = 4'b0010;
        cyc();
        chk("same_grant1", 32'(grant), 32'b0010);
        cyc();
        done = 4'b0010; req = 4'b0011;
        cyc();
        done = '0; req = 4'b0001;
        chk("same_rel", 32'(grant), 0);
        cyc(); chk("same_gap2", 32'(grant), 0);
        cyc(); chk("same_gap3", 32'(grant), 0);
        cyc(); chk("same_w0", 32'(grant), 32'b0001);

        // Random traffic against the model
        do_reset();
        repeat (400) begin
            if ($urandom_range(0, 9) < 3) req = 4'($urandom);
            done     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            temp_sel = 8'($urandom);
            rst      = ($urandom_range(0, 99) == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
